op_amp_cal_ctrl: RTL and testbench

OP_AMP_CAL_CTRL -- requirements
Module: op_amp_cal_ctrl

---
 rtl/op_amp_cal_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_op_amp_cal_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/op_amp_cal_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : op_amp_cal_ctrl
// Purpose  : Op-amp front-end driver with SAR offset-trim calibration.
// Revision : 1.0 - initial release
// ============================================================================
module op_amp_cal_ctrl #(
  parameter int WIDTH  = 16,
  parameter int TRIM_W = 6,
  parameter int SETTLE = 4,
  parameter int TOL    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cal_start,
  input  logic signed [WIDTH-1:0]  in_p,
  input  logic signed [WIDTH-1:0]  in_n,
  input  logic signed [WIDTH-1:0]  amp_out,
  output logic signed [WIDTH-1:0]  amp_inp,
  output logic signed [WIDTH-1:0]  amp_inn,
  output logic signed [TRIM_W-1:0] trim,
  output logic                     null_p,
  output logic                     null_n,
  output logic                     cal_busy,
  output logic                     cal_done,
  output logic                     cal_err
);

  localparam int MAG_W = TRIM_W - 1;
  localparam int BIT_W = (MAG_W > 1) ? $clog2(MAG_W) : 1;
  localparam int CNT_W = $clog2(SETTLE + 1);

  localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE - 1);
  localparam logic [BIT_W-1:0] c_bit_msb     = BIT_W'(MAG_W - 1);
  localparam logic [MAG_W-1:0] c_mag_msb     = MAG_W'(1) << (MAG_W - 1);
  localparam logic [WIDTH:0]   c_tol         = (WIDTH+1)'(TOL);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SIGN_WAIT = 3'd1,
    S_SIGN_EVAL = 3'd2,
    S_BIT_WAIT  = 3'd3,
    S_BIT_EVAL  = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [MAG_W-1:0]   mag_q, mag_d;
  logic               sign_q, sign_d;
  logic [TRIM_W-1:0]  trim_trial_q, trim_trial_d;
  logic [TRIM_W-1:0]  trim_q, trim_d;
  logic               null_p_q, null_p_d;
  logic               null_n_q, null_n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               w_amp_zero, w_amp_pos, w_amp_neg, w_keep, w_over_tol;
  logic [WIDTH:0]     w_amp_ext, w_amp_abs;
  logic [MAG_W-1:0]   w_bit_mask, w_mag_kept, w_mag_next;
  logic [TRIM_W-1:0]  w_first_trial, w_next_trial, w_final_trial;
  logic [WIDTH-1:0]   w_trim_ext, w_trial_ext, w_sat;
  logic [WIDTH:0]     w_sum;

  // Sign-magnitude to two's complement; magnitude never reaches -2^(TRIM_W-1).
  function automatic logic [TRIM_W-1:0] to_trial(input logic neg,
                                                 input logic [MAG_W-1:0] mag);
    logic [TRIM_W-1:0] m;
    m = {1'b0, mag};
    return neg ? (~m + 1'b1) : m;
  endfunction

  always_comb begin
    w_amp_neg     = amp_out[WIDTH-1];
    w_amp_zero    = (amp_out == '0);
    w_amp_pos     = !w_amp_neg && !w_amp_zero;
    w_keep        = w_amp_zero || (sign_q ? w_amp_pos : w_amp_neg);
    w_amp_ext     = {amp_out[WIDTH-1], amp_out};
    w_amp_abs     = w_amp_neg ? (~w_amp_ext + 1'b1) : w_amp_ext;
    w_over_tol    = (w_amp_abs > c_tol);
    w_bit_mask    = MAG_W'(1) << bit_q;
    w_mag_kept    = w_keep ? mag_q : (mag_q & ~w_bit_mask);
    w_mag_next    = w_mag_kept | (w_bit_mask >> 1);
    w_first_trial = to_trial(w_amp_pos, c_mag_msb);
    w_next_trial  = to_trial(sign_q, w_mag_next);
    w_final_trial = to_trial(sign_q, w_mag_kept);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    mag_d        = mag_q;
    sign_d       = sign_q;
    trim_trial_d = trim_trial_q;
    trim_d       = trim_q;
    null_p_d     = null_p_q;
    null_n_d     = null_n_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (cal_start) begin
          state_d      = S_SIGN_WAIT;
          busy_d       = 1'b1;
          err_d        = 1'b0;
          cnt_d        = '0;
          bit_d        = c_bit_msb;
          mag_d        = '0;
          trim_trial_d = '0;
        end
      end
      S_SIGN_WAIT: begin
        if (cnt_q == c_settle_last) begin
          state_d = S_SIGN_EVAL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SIGN_EVAL: begin
        if (w_amp_zero) begin
          // No offset seen: commit a zero trim straight away.
          state_d      = S_DONE;
          trim_trial_d = '0;
          trim_d       = '0;
          null_p_d     = 1'b0;
          null_n_d     = 1'b0;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          err_d        = w_over_tol;
        end else begin
          state_d      = S_BIT_WAIT;
          sign_d       = w_amp_pos;
          mag_d        = c_mag_msb;
          trim_trial_d = w_first_trial;
          cnt_d        = '0;
        end
      end
      S_BIT_WAIT: begin
        if (cnt_q == c_settle_last) begin
          state_d = S_BIT_EVAL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BIT_EVAL: begin
        if (bit_q == '0) begin
          state_d      = S_DONE;
          mag_d        = w_mag_kept;
          trim_trial_d = w_final_trial;
          trim_d       = w_final_trial;
          null_p_d     = !w_final_trial[TRIM_W-1] && (w_final_trial != '0);
          null_n_d     = w_final_trial[TRIM_W-1];
          busy_d       = 1'b0;
          done_d       = 1'b1;
          err_d        = w_over_tol;
        end else begin
          state_d      = S_BIT_WAIT;
          mag_d        = w_mag_next;
          trim_trial_d = w_next_trial;
          bit_d        = bit_q - BIT_W'(1);
          cnt_d        = '0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      mag_q        <= '0;
      sign_q       <= 1'b0;
      trim_trial_q <= '0;
      trim_q       <= '0;
      null_p_q     <= 1'b0;
      null_n_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      mag_q        <= mag_d;
      sign_q       <= sign_d;
      trim_trial_q <= trim_trial_d;
      trim_q       <= trim_d;
      null_p_q     <= null_p_d;
      null_n_q     <= null_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Amplifier drive: trimmed user signal in IDLE, trial trim alone while calibrating.
  always_comb begin
    w_trim_ext  = {{(WIDTH-TRIM_W){trim_q[TRIM_W-1]}}, trim_q};
    w_trial_ext = {{(WIDTH-TRIM_W){trim_trial_q[TRIM_W-1]}}, trim_trial_q};
    w_sum       = {in_p[WIDTH-1], in_p} + {w_trim_ext[WIDTH-1], w_trim_ext};
    if (w_sum[WIDTH] != w_sum[WIDTH-1]) begin
      w_sat = w_sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      w_sat = w_sum[WIDTH-1:0];
    end
    if (state_q == S_IDLE) begin
      amp_inp = w_sat;
      amp_inn = in_n;
    end else begin
      amp_inp = w_trial_ext;
      amp_inn = '0;
    end
  end

  assign trim     = trim_q;
  assign null_p   = null_p_q;
  assign null_n   = null_n_q;
  assign cal_busy = busy_q;
  assign cal_done = done_q;
  assign cal_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_op_amp_cal_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_op_amp_cal_ctrl
// Purpose  : Scoreboard bench with amplifier model for op_amp_cal_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_op_amp_cal_ctrl;

  localparam int WIDTH    = 16;
  localparam int TRIM_W   = 6;
  localparam int SETTLE   = 4;
  localparam int TOL      = 8;
  localparam int FULL_LAT = (SETTLE + 1) * TRIM_W;
  localparam int ZERO_LAT = SETTLE + 1;
  localparam int SMAX     = 32767;
  localparam int SMIN     = -32768;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cal_start = 1'b0;
  logic signed [WIDTH-1:0]  in_p = '0;
  logic signed [WIDTH-1:0]  in_n = '0;
  logic signed [WIDTH-1:0]  amp_out = '0;
  logic signed [WIDTH-1:0]  amp_inp, amp_inn;
  logic signed [TRIM_W-1:0] trim;
  logic null_p, null_n, cal_busy, cal_done, cal_err;

  logic signed [WIDTH-1:0] pipe0 = '0;
  logic signed [WIDTH-1:0] pipe1 = '0;
  int ofs = 0;
  int cyc = 0;
  int cur_trim = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int trim;
    bit err;
    int acc_cyc;
    int lat;
  } exp_t;
  exp_t sb[$];

  op_amp_cal_ctrl #(.WIDTH(WIDTH), .TRIM_W(TRIM_W), .SETTLE(SETTLE), .TOL(TOL)) dut (
    .clk(clk), .rst_n(rst_n), .cal_start(cal_start),
    .in_p(in_p), .in_n(in_n), .amp_out(amp_out),
    .amp_inp(amp_inp), .amp_inn(amp_inn), .trim(trim),
    .null_p(null_p), .null_n(null_n),
    .cal_busy(cal_busy), .cal_done(cal_done), .cal_err(cal_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sat(input int v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  // Amplifier: gain 8 on differential input plus offset, three clocks of delay.
  always @(posedge clk) begin
    pipe0   <= WIDTH'(sat(8 * (int'(amp_inp) - int'(amp_inn) + ofs)));
    pipe1   <= pipe0;
    amp_out <= pipe1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Successive approximation of the offset, bit weights tried largest first.
  function automatic exp_t ref_cal(input int o);
    exp_t e;
    int s0, mag, trial, r, last;
    bit neg;
    s0 = sat(8 * o);
    e.acc_cyc = 0;
    if (s0 == 0) begin
      e.trim = 0; e.err = 1'b0; e.lat = ZERO_LAT;
      return e;
    end
    neg = (s0 > 0);
    mag = 0;
    last = 0;
    for (int b = TRIM_W - 2; b >= 0; b--) begin
      trial = mag + (1 << b);
      r = sat(8 * ((neg ? -trial : trial) + o));
      if (r == 0 || (neg ? r > 0 : r < 0)) mag = trial;
      last = r;
    end
    e.trim = neg ? -mag : mag;
    e.err  = ((last < 0) ? -last : last) > TOL;
    e.lat  = FULL_LAT;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && cal_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_latency", cyc - e.acc_cyc, e.lat);
        chk("trim", int'(trim), e.trim);
        chk("null_p", int'(null_p), int'(e.trim > 0));
        chk("null_n", int'(null_n), int'(e.trim < 0));
        chk("cal_err", int'(cal_err), int'(e.err));
        chk("busy_at_done", int'(cal_busy), 0);
      end
    end
  end

  // Called at a negedge; returns one negedge after the request was accepted.
  task automatic start_cal(input int o);
    exp_t e;
    ofs = o;
    e = ref_cal(o);
    e.acc_cyc = cyc + 1;
    in_p = WIDTH'($urandom);
    in_n = WIDTH'($urandom);
    cal_start = 1'b1;
    sb.push_back(e);
    cur_trim = e.trim;
    @(negedge clk);
    cal_start = 1'b0;
    chk("busy_after_start", int'(cal_busy), 1);
    chk("err_cleared_on_start", int'(cal_err), 0);
    chk("amp_inp_cal", int'(amp_inp), 0);
    chk("amp_inn_cal", int'(amp_inn), 0);
  endtask

  task automatic wait_done();
    for (int k = 0; k < FULL_LAT + 20 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("done_timeout", 1, 0);
      sb.delete();
    end
    @(negedge clk);
    chk("done_pulse_low", int'(cal_done), 0);
  endtask

  task automatic idle_check(input int p, input int n);
    in_p = WIDTH'(p);
    in_n = WIDTH'(n);
    #1;
    chk("amp_inp_idle", int'(amp_inp), sat(p + cur_trim));
    chk("amp_inn_idle", int'(amp_inn), n);
    @(negedge clk);
  endtask

  task automatic reset_values();
    chk("rst_trim", int'(trim), 0);
    chk("rst_busy", int'(cal_busy), 0);
    chk("rst_done", int'(cal_done), 0);
    chk("rst_err", int'(cal_err), 0);
    chk("rst_null_p", int'(null_p), 0);
    chk("rst_null_n", int'(null_n), 0);
    chk("rst_amp_inp", int'(amp_inp), int'(in_p));
    chk("rst_amp_inn", int'(amp_inn), int'(in_n));
  endtask

  initial begin
    in_p = 16'sd1234;
    in_n = -16'sd77;
    repeat (3) @(negedge clk);
    #1;
    reset_values();
    @(negedge clk);
    rst_n = 1'b1;

    // Request on the first edge after release must be taken.
    start_cal(5);
    wait_done();
    idle_check(-300, 45);

    start_cal(-12);
    wait_done();
    idle_check(100, 0);

    start_cal(0);
    wait_done();
    idle_check(2000, -2000);

    start_cal(40);
    wait_done();
    repeat (5) @(negedge clk);
    chk("err_holds", int'(cal_err), 1);
    chk("trim_holds", int'(trim), -31);

    start_cal(-40);
    wait_done();
    idle_check(32767, 0);
    idle_check(-32768, 5);

    for (int i = 0; i < 10; i++) begin
      start_cal(int'($urandom_range(90)) - 45);
      wait_done();
      idle_check(int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768);
    end

    // Asynchronous reset in the middle of a calibration.
    start_cal(-12);
    wait_done();
    start_cal(5);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    reset_values();
    sb.delete();
    cur_trim = 0;
    @(negedge clk);
    #1;
    reset_values();
    @(negedge clk);
    rst_n = 1'b1;

    // A second request mid-run must not restart the sequence.
    start_cal(5);
    repeat (6) @(negedge clk);
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    chk("busy_mid_run", int'(cal_busy), 1);
    wait_done();
    idle_check(1000, 10);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
